// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one burst memory port between ICache and DCache, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise DCache has fixed priority.
module mem_bus_arbiter #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    input  logic [LEN_W-1:0] i_len,
    output logic             i_gnt,
    output logic [31:0]      i_rdata,
    output logic             i_rvalid,
    output logic             i_rlast,
    input  logic             d_req,
    input  logic             d_wr,
    input  logic [31:0]      d_addr,
    input  logic [LEN_W-1:0] d_len,
    input  logic [31:0]      d_wdata,
    input  logic [3:0]       d_wstrb,
    output logic             d_gnt,
    output logic             d_wready,
    output logic [31:0]      d_rdata,
    output logic             d_rvalid,
    output logic             d_rlast,
    output logic             d_bdone,
    output logic             m_req,
    output logic             m_wr,
    output logic [31:0]      m_addr,
    output logic [LEN_W-1:0] m_len,
    input  logic             m_addr_ok,
    output logic [31:0]      m_wdata,
    output logic [3:0]       m_wstrb,
    output logic             m_wvalid,
    output logic             m_wlast,
    input  logic             m_wready,
    input  logic [31:0]      m_rdata,
    input  logic             m_rvalid,
    input  logic             m_rlast,
    input  logic             m_bvalid
);
    typedef enum logic [2:0] {IDLE, ADDR, RDATA, WDATA, WRESP} state_t;
    state_t           state, state_nx;
    logic             own_d, wr_q, pick_d;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] len_q, cnt;
    logic             in_addr, in_rd, in_wd, rd_i, rd_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;
    assign pick_d = d_req && (!i_req || !last_d);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_d <= 1'b0;
        else if (state == ADDR && m_addr_ok) last_d <= own_d;
    end
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            own_d  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (i_req || d_req)) begin
                own_d  <= pick_d;
                wr_q   <= pick_d & d_wr;
                addr_q <= pick_d ? d_addr : i_addr;
                len_q  <= pick_d ? d_len : i_len;
            end
            // outside WDATA the counter sits at zero, so every burst starts at beat 0
            if (state != WDATA) cnt <= '0;
            else if (m_wready) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_req || d_req) state_nx = ADDR;
            ADDR:    if (m_addr_ok) state_nx = wr_q ? WDATA : RDATA;
            RDATA:   if (m_rvalid && m_rlast) state_nx = IDLE;
            WDATA:   if (m_wready && m_wlast) state_nx = WRESP;
            WRESP:   if (m_bvalid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_addr = state == ADDR;
    assign in_rd   = state == RDATA;
    assign in_wd   = state == WDATA;
    assign rd_i    = in_rd & ~own_d;
    assign rd_d    = in_rd & own_d;

    assign m_req    = in_addr;
    assign m_wr     = in_addr & wr_q;
    assign m_addr   = in_addr ? addr_q : '0;
    assign m_len    = in_addr ? len_q : '0;
    assign i_gnt    = in_addr & m_addr_ok & ~own_d;
    assign d_gnt    = in_addr & m_addr_ok & own_d;

    assign i_rdata  = rd_i ? m_rdata : '0;
    assign i_rvalid = rd_i & m_rvalid;
    assign i_rlast  = rd_i & m_rvalid & m_rlast;
    assign d_rdata  = rd_d ? m_rdata : '0;
    assign d_rvalid = rd_d & m_rvalid;
    assign d_rlast  = rd_d & m_rvalid & m_rlast;

    assign m_wvalid = in_wd;
    assign m_wdata  = in_wd ? d_wdata : '0;
    assign m_wstrb  = in_wd ? d_wstrb : '0;
    assign m_wlast  = in_wd & (cnt == len_q);
    assign d_wready = in_wd & m_wready;
    assign d_bdone  = (state == WRESP) & m_bvalid;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized scoreboard bench with a cycle-level memory slave model.
// Grant-order expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_bus_arbiter;
    localparam int LEN_W = 4;
    localparam int TO = 400;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic i_req, i_gnt, i_rvalid, i_rlast;
    logic [31:0] i_addr, i_rdata;
    logic [LEN_W-1:0] i_len;
    logic d_req, d_wr, d_gnt, d_wready, d_rvalid, d_rlast, d_bdone;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [LEN_W-1:0] d_len;
    logic [3:0] d_wstrb;
    logic m_req, m_wr, m_addr_ok, m_wvalid, m_wlast, m_wready, m_rvalid, m_rlast, m_bvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [LEN_W-1:0] m_len;
    logic [3:0] m_wstrb;

    mem_bus_arbiter #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_gnt(i_gnt),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_len(d_len),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_wready(d_wready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_bdone(d_bdone),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_len(m_len), .m_addr_ok(m_addr_ok),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wlast(m_wlast),
        .m_wready(m_wready), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
        .m_bvalid(m_bvalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit last_d = 1'b0;
    bit inject_b = 1'b0;
    bit gnt_q[$];
    bit bq[$];
    logic [36:0] iaq[$], daq[$], wq[$];
    logic [32:0] iq[$], dq[$];

    logic any_out;
    assign any_out = |{i_gnt, i_rdata, i_rvalid, i_rlast, d_gnt, d_wready, d_rdata, d_rvalid,
                       d_rlast, d_bdone, m_req, m_wr, m_addr, m_len, m_wdata, m_wstrb,
                       m_wvalid, m_wlast};

    function automatic logic [31:0] rd_word(input logic [31:0] a, input int b);
        return a ^ (32'h9e3779b9 * (b + 1));
    endfunction

    function automatic logic [LEN_W-1:0] rand_len();
        return ($urandom_range(0, 3) == 0) ? '0 : LEN_W'($urandom_range(0, 15));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing after %0d cycles, required it to occur", name, TO);
    endtask

    // Reference arbitration: ni ICache and nd DCache requests pending (DCache re-requests back to back).
    task automatic expect_grants(input int ni, input int nd);
        bit pick;
        while (ni + nd > 0) begin
            if (ni > 0 && nd > 0) pick = RR ? !last_d : 1'b1;
            else pick = nd > 0;
            gnt_q.push_back(pick);
            last_d = pick;
            if (pick) nd--;
            else ni--;
        end
    endtask

    task automatic i_txn(input logic [31:0] a, input logic [LEN_W-1:0] l);
        int n;
        iaq.push_back({1'b0, a, l});
        for (int b = 0; b <= int'(l); b++) iq.push_back({rd_word(a, b), b == int'(l)});
        i_req = 1'b1; i_addr = a; i_len = l;
        n = 0;
        do begin @(negedge clk); n++; end while (!i_gnt && n < TO);
        if (!i_gnt) tmo("i_gnt_wait");
        @(posedge clk); #1;
        i_req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(i_rvalid && i_rlast) && n < TO);
        if (!(i_rvalid && i_rlast)) tmo("i_read_done");
        @(posedge clk); #1;
    endtask

    task automatic d_txn(input bit wr, input logic [31:0] a, input logic [LEN_W-1:0] l);
        logic [31:0] wb[$];
        logic [3:0] sb[$];
        logic [31:0] w;
        logic [3:0] s;
        int n, k;
        bit hs;
        daq.push_back({wr, a, l});
        for (int b = 0; b <= int'(l); b++) begin
            if (wr) begin
                w = $urandom; s = 4'($urandom);
                wb.push_back(w); sb.push_back(s);
                wq.push_back({w, s, b == int'(l)});
            end else dq.push_back({rd_word(a, b), b == int'(l)});
        end
        if (wr) bq.push_back(1'b1);
        d_req = 1'b1; d_wr = wr; d_addr = a; d_len = l;
        d_wdata = wr ? wb[0] : '0; d_wstrb = wr ? sb[0] : '0;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_gnt && n < TO);
        if (!d_gnt) tmo("d_gnt_wait");
        @(posedge clk); #1;
        d_req = 1'b0;
        n = 0;
        if (wr) begin
            k = 0;
            while (k <= int'(l) && n < TO) begin
                d_wdata = wb[k]; d_wstrb = sb[k];
                @(negedge clk); n++;
                hs = d_wready;
                @(posedge clk); #1;
                if (hs) k++;
            end
            if (k <= int'(l)) tmo("d_write_beats");
            n = 0;
            do begin @(negedge clk); n++; end while (!d_bdone && n < TO);
            if (!d_bdone) tmo("d_bdone_wait");
        end else begin
            do begin @(negedge clk); n++; end while (!(d_rvalid && d_rlast) && n < TO);
            if (!(d_rvalid && d_rlast)) tmo("d_read_done");
        end
        @(posedge clk); #1;
    endtask

    // Memory slave: random accept latency, read gaps, wready toggling, response delay, stray strobes.
    typedef enum {MS_IDLE, MS_ADDR, MS_R, MS_W, MS_B} ms_t;
    ms_t ms = MS_IDLE;
    logic mwr;
    logic [31:0] maddr;
    logic [LEN_W-1:0] mlen;
    int beat, dly;

    initial begin
        m_addr_ok = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        m_rdata = '0; beat = 0; dly = 0; mwr = 1'b0; maddr = '0; mlen = '0;
        forever begin
            @(posedge clk); #1;
            m_addr_ok = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
            m_rdata = $urandom;
            if (!reset) ms = MS_IDLE;
            else begin
                if (ms == MS_IDLE) begin
                    if (m_req) begin
                        mwr = m_wr; maddr = m_addr; mlen = m_len; beat = 0;
                        dly = $urandom_range(0, 2);
                        ms = MS_ADDR;
                    end else begin
                        m_bvalid = inject_b || $urandom_range(0, 7) == 0;
                        m_rvalid = $urandom_range(0, 7) == 0;
                        m_rlast = m_rvalid;
                    end
                end
                if (ms == MS_ADDR) begin
                    m_rvalid = $urandom_range(0, 3) == 0;
                    m_rlast = $urandom_range(0, 1) == 1;
                    if (dly == 0) begin
                        m_addr_ok = 1'b1;
                        ms = mwr ? MS_W : MS_R;
                    end else dly--;
                end else if (ms == MS_R) begin
                    if ($urandom_range(0, 3) != 0) begin
                        m_rvalid = 1'b1;
                        m_rdata = rd_word(maddr, beat);
                        m_rlast = beat == int'(mlen);
                        if (m_rlast) ms = MS_IDLE;
                        beat++;
                    end else m_bvalid = $urandom_range(0, 3) == 0;
                end else if (ms == MS_W) begin
                    m_wready = $urandom_range(0, 1) == 1;
                    m_rvalid = $urandom_range(0, 3) == 0;
                    m_rlast = m_rvalid;
                    if (m_wready && m_wvalid) begin
                        beat++;
                        if (beat == int'(mlen) + 1) begin
                            ms = MS_B;
                            dly = $urandom_range(0, 3);
                        end
                    end
                end else if (ms == MS_B) begin
                    m_rvalid = $urandom_range(0, 3) == 0;
                    m_rlast = m_rvalid;
                    if (dly == 0) begin
                        m_bvalid = 1'b1;
                        ms = MS_IDLE;
                    end else dly--;
                end
            end
        end
    end

    bit mon_own;
    always @(negedge clk) begin
        if (i_gnt || d_gnt) begin
            if (gnt_q.size() == 0) chk("gnt_unexpected", 64'({i_gnt, d_gnt}), 64'(0));
            else begin
                mon_own = gnt_q.pop_front();
                chk("gnt_owner", 64'({i_gnt, d_gnt}), mon_own ? 64'(2'b01) : 64'(2'b10));
                if ((mon_own ? daq.size() : iaq.size()) == 0) chk("addr_phase_unexpected", 64'(m_req), 64'(0));
                else chk("addr_phase", 64'({m_wr, m_addr, m_len}), 64'(mon_own ? daq.pop_front() : iaq.pop_front()));
            end
        end
        if (i_rvalid && d_rvalid) chk("rvalid_both", 64'({i_rvalid, d_rvalid}), 64'(0));
        if (i_rvalid) begin
            if (iq.size() == 0) chk("i_rvalid_unexpected", 64'(i_rvalid), 64'(0));
            else chk("i_rbeat", 64'({i_rdata, i_rlast}), 64'(iq.pop_front()));
        end
        if (d_rvalid) begin
            if (dq.size() == 0) chk("d_rvalid_unexpected", 64'(d_rvalid), 64'(0));
            else chk("d_rbeat", 64'({d_rdata, d_rlast}), 64'(dq.pop_front()));
        end
        if (m_wvalid && m_wready) begin
            if (wq.size() == 0) chk("wbeat_unexpected", 64'({m_wvalid, m_wready}), 64'(0));
            else chk("wbeat", 64'({m_wdata, m_wstrb, m_wlast}), 64'(wq.pop_front()));
        end
        if (d_bdone) begin
            if (bq.size() == 0) chk("bdone_unexpected", 64'(d_bdone), 64'(0));
            else chk("bdone", 64'(d_bdone), 64'(bq.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    int kind, n, k;
    bit wr_r;
    logic [31:0] a1, a2, a3;

    initial begin
        reset = 1'b0;
        i_req = 1'b0; i_addr = '0; i_len = '0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_len = '0; d_wdata = '0; d_wstrb = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(any_out), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        expect_grants(1, 0); i_txn(32'h1fc0_0000, 4'd7);
        expect_grants(0, 1); d_txn(1'b1, 32'h8000_0040, 4'd3);
        expect_grants(0, 1); d_txn(1'b0, 32'h8000_1000, 4'd0);

        inject_b = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_bvalid_bdone", 64'(d_bdone), 64'(0));
            chk("idle_bvalid_mreq", 64'(m_req), 64'(0));
        end
        @(posedge clk); #1;
        inject_b = 1'b0;

        expect_grants(1, 2);
        fork
            i_txn(32'h0000_4000, 4'd2);
            begin
                d_txn(1'b0, 32'h9000_0000, 4'd1);
                d_txn(1'b1, 32'h9000_0100, 4'd2);
            end
        join

        repeat (3) begin
            expect_grants(1, 1);
            a1 = $urandom & 32'hffff_fffc;
            a2 = $urandom & 32'hffff_fffc;
            wr_r = 1'($urandom_range(0, 1));
            fork
                i_txn(a1, rand_len());
                d_txn(wr_r, a2, rand_len());
            join
        end

        expect_grants(1, 0);
        iaq.push_back({1'b0, 32'h0000_2000, 4'd7});
        for (int b = 0; b <= 7; b++) iq.push_back({rd_word(32'h0000_2000, b), b == 7});
        i_req = 1'b1; i_addr = 32'h0000_2000; i_len = 4'd7;
        n = 0;
        do begin @(negedge clk); n++; end while (!i_gnt && n < TO);
        if (!i_gnt) tmo("rst_gnt_wait");
        @(posedge clk); #1;
        i_req = 1'b0;
        k = 0; n = 0;
        while (k < 3 && n < TO) begin
            @(negedge clk); n++;
            if (i_rvalid) k++;
        end
        if (k < 3) tmo("rst_beat3_wait");
        #2 reset = 1'b0;
        #1 chk("async_reset_outputs", 64'(any_out), 64'(0));
        iq.delete();
        last_d = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_reset_outputs", 64'(any_out), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", 64'(m_req), 64'(0));
        expect_grants(1, 1);
        fork
            i_txn(32'h0000_3000, 4'd1);
            d_txn(1'b1, 32'h0000_3100, 4'd0);
        join

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 4);
            a1 = $urandom & 32'hffff_fffc;
            a2 = $urandom & 32'hffff_fffc;
            a3 = $urandom & 32'hffff_fffc;
            wr_r = 1'($urandom_range(0, 1));
            if (kind == 0) begin
                expect_grants(1, 0); i_txn(a1, rand_len());
            end else if (kind == 1) begin
                expect_grants(0, 1); d_txn(1'b0, a2, rand_len());
            end else if (kind == 2) begin
                expect_grants(0, 1); d_txn(1'b1, a2, rand_len());
            end else if (kind == 3) begin
                expect_grants(1, 1);
                fork
                    i_txn(a1, rand_len());
                    d_txn(wr_r, a2, rand_len());
                join
            end else begin
                expect_grants(1, 2);
                fork
                    i_txn(a1, rand_len());
                    begin
                        d_txn(wr_r, a2, rand_len());
                        d_txn(!wr_r, a3, rand_len());
                    end
                join
            end
        end

        repeat (5) @(negedge clk);
        chk("gnt_q_drained", 64'(gnt_q.size()), 64'(0));
        chk("iaq_drained", 64'(iaq.size()), 64'(0));
        chk("daq_drained", 64'(daq.size()), 64'(0));
        chk("iq_drained", 64'(iq.size()), 64'(0));
        chk("dq_drained", 64'(dq.size()), 64'(0));
        chk("wq_drained", 64'(wq.size()), 64'(0));
        chk("bq_drained", 64'(bq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
